// File: rtl/k2_fetch_unit.sv
// K2 instruction fetch stage: owns the PC, reads the combinational program ROM
// and hands registered instruction bytes to decode over a valid/ready handshake.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | after reset; waiting for start, jumps are ignored
// S_RUN  | fetching; one ROM word per cycle while decode keeps up
// S_HALT | fetch stopped by halt_req or a bad jump; pc held for resume
module k2_fetch_unit #(
    parameter int ADDR_W   = 4,
    parameter int DATA_W   = 8,
    parameter int PROG_LEN = 9
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              halt_req_i,
    input  logic              jmp_valid_i,
    input  logic [ADDR_W-1:0] jmp_addr_i,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_pc_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i,
    output logic              running_o,
    output logic              jmp_err_o
);

    // One extra bit so PROG_LEN == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0]   PROG_LEN_W = (ADDR_W+1)'(PROG_LEN);
    localparam logic [ADDR_W-1:0] LAST_PC    = ADDR_W'(PROG_LEN - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [DATA_W-1:0]   instr_q, instr_d;
    logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;

    logic jmp_take;
    logic jmp_bad;
    logic load;

    assign jmp_take = jmp_valid_i && (state_q != S_IDLE);
    assign jmp_bad  = jmp_take && ({1'b0, jmp_addr_i} >= PROG_LEN_W);
    assign load     = (state_q == S_RUN) && !halt_req_i && !jmp_take &&
                      (!valid_q || instr_ready_i);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            valid_q    <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
            valid_q    <= valid_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;
        valid_d    = valid_q;
        err_d      = err_q;

        case (state_q)
            S_IDLE: if (start_i) state_d = S_RUN;
            S_RUN:  if (halt_req_i) state_d = S_HALT;
            S_HALT: begin
                if (start_i && !halt_req_i) begin
                    state_d = S_RUN;
                    err_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (load) begin
            instr_d    = rom_data_i;
            instr_pc_d = pc_q;
            valid_d    = 1'b1;
            pc_d       = (pc_q == LAST_PC) ? '0 : pc_q + 1'b1;
        end else if (valid_q && instr_ready_i) begin
            valid_d = 1'b0;
        end

        // A redirect flushes the output word, even one stalled by decode.
        if (jmp_take) begin
            valid_d = 1'b0;
            if (jmp_bad) begin
                err_d   = 1'b1;
                state_d = S_HALT;
            end else begin
                pc_d = jmp_addr_i;
            end
        end
    end

    assign rom_addr_o    = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = valid_q;
    assign running_o     = (state_q == S_RUN);
    assign jmp_err_o     = err_q;

endmodule

// File: tb/tb_k2_fetch_unit.sv
// Bench for k2_fetch_unit: directed scenarios push expected words into a
// scoreboard queue; a negedge monitor pops one entry per handshake.
module tb_k2_fetch_unit;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       halt_req;
    logic       jmp_valid;
    logic [3:0] jmp_addr;
    logic [3:0] rom_addr;
    logic [7:0] rom_data;
    logic [7:0] instr;
    logic [3:0] instr_pc;
    logic       instr_valid;
    logic       instr_ready;
    logic       running;
    logic       jmp_err;

    logic [7:0] rom [16];

    typedef struct packed {
        logic [7:0] instr;
        logic [3:0] pc;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;
    int   n_vec;
    int   n_err;

    k2_fetch_unit #(.ADDR_W(4), .DATA_W(8), .PROG_LEN(9)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .start_i       (start),
        .halt_req_i    (halt_req),
        .jmp_valid_i   (jmp_valid),
        .jmp_addr_i    (jmp_addr),
        .rom_addr_o    (rom_addr),
        .rom_data_i    (rom_data),
        .instr_o       (instr),
        .instr_pc_o    (instr_pc),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready),
        .running_o     (running),
        .jmp_err_o     (jmp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign rom_data = rom[rom_addr];

    always @(negedge clk) begin
        if (rst_n && instr_valid && instr_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_word: got instr=%h pc=%0d, required no word", instr, instr_pc);
            end else begin
                e = exp_q.pop_front();
                if (instr !== e.instr || instr_pc !== e.pc) begin
                    n_err++;
                    $display("FAIL stream_word: got instr=%h pc=%0d, required instr=%h pc=%0d",
                             instr, instr_pc, e.instr, e.pc);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input logic [3:0] p);
        exp_q.push_back({d, p});
    endtask

    task automatic do_reset();
        start       = 1'b0;
        halt_req    = 1'b0;
        jmp_valid   = 1'b0;
        jmp_addr    = 4'd0;
        instr_ready = 1'b1;
        rst_n       = 1'b0;
        #1;
        check("rst_valid",    32'(instr_valid), 32'd0);
        check("rst_instr",    32'(instr),       32'h00);
        check("rst_instr_pc", 32'(instr_pc),    32'd0);
        check("rst_rom_addr", 32'(rom_addr),    32'd0);
        check("rst_running",  32'(running),     32'd0);
        check("rst_jmp_err",  32'(jmp_err),     32'd0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic start_pulse();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic end_scn(input string name);
        repeat (3) tick();
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        logic [7:0] prog [9];
        prog = '{8'h08, 8'h19, 8'h20, 8'h10, 8'h70, 8'h00, 8'h14, 8'h04, 8'hB2};
        for (int i = 0; i < 16; i++) rom[i] = 8'hEE;
        for (int i = 0; i < 9; i++) rom[i] = prog[i];
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        #2;
        do_reset();

        // 1: full program plus wrap to address 0
        for (int i = 0; i < 9; i++) push(prog[i], 4'(i));
        push(8'h08, 4'd0);
        start_pulse();
        repeat (10) tick();
        halt_req = 1'b1;
        repeat (2) tick();
        check("s1_running", 32'(running), 32'd0);
        end_scn("s1_drained");

        // 2: three-cycle stall on 20
        do_reset();
        for (int i = 0; i < 5; i++) push(prog[i], 4'(i));
        start_pulse();
        repeat (3) tick();
        instr_ready = 1'b0;
        repeat (3) begin
            check("s2_stall_instr", 32'(instr),       32'h20);
            check("s2_stall_pc",    32'(instr_pc),    32'd2);
            check("s2_stall_valid", 32'(instr_valid), 32'd1);
            tick();
        end
        instr_ready = 1'b1;
        repeat (2) tick();
        halt_req = 1'b1;
        end_scn("s2_drained");

        // 3: jump to 6 while 19 is stalled
        do_reset();
        push(8'h08, 4'd0);
        push(8'h14, 4'd6);
        push(8'h04, 4'd7);
        push(8'hB2, 4'd8);
        start_pulse();
        repeat (2) tick();
        instr_ready = 1'b0;
        jmp_valid   = 1'b1;
        jmp_addr    = 4'd6;
        tick();
        jmp_valid = 1'b0;
        check("s3_flush_valid", 32'(instr_valid), 32'd0);
        check("s3_target_pc",   32'(rom_addr),    32'd6);
        instr_ready = 1'b1;
        repeat (3) tick();
        halt_req = 1'b1;
        end_scn("s3_drained");

        // 4: bad jump, then resume at held pc
        do_reset();
        push(8'h08, 4'd0);
        push(8'h20, 4'd2);
        push(8'h10, 4'd3);
        start_pulse();
        repeat (2) tick();
        instr_ready = 1'b0;
        jmp_valid   = 1'b1;
        jmp_addr    = 4'd12;
        tick();
        jmp_valid = 1'b0;
        check("s4_jmp_err",  32'(jmp_err),     32'd1);
        check("s4_running",  32'(running),     32'd0);
        check("s4_valid",    32'(instr_valid), 32'd0);
        check("s4_held_pc",  32'(rom_addr),    32'd2);
        instr_ready = 1'b1;
        tick();
        start_pulse();
        check("s4_err_clear", 32'(jmp_err), 32'd0);
        check("s4_resumed",   32'(running), 32'd1);
        repeat (2) tick();
        halt_req = 1'b1;
        end_scn("s4_drained");

        // 5: halt with 70 stalled, then resume at pc 5
        do_reset();
        for (int i = 0; i < 6; i++) push(prog[i], 4'(i));
        start_pulse();
        repeat (5) tick();
        halt_req    = 1'b1;
        instr_ready = 1'b0;
        repeat (2) tick();
        check("s5_held_instr", 32'(instr),       32'h70);
        check("s5_held_valid", 32'(instr_valid), 32'd1);
        check("s5_running",    32'(running),     32'd0);
        instr_ready = 1'b1;
        repeat (3) tick();
        check("s5_no_more",    32'(instr_valid), 32'd0);
        check("s5_pc_held",    32'(rom_addr),    32'd5);
        halt_req = 1'b0;
        start_pulse();
        tick();
        halt_req = 1'b1;
        end_scn("s5_drained");

        // 6: asynchronous reset between clock edges
        do_reset();
        push(8'h08, 4'd0);
        push(8'h19, 4'd1);
        start_pulse();
        repeat (3) tick();
        #2;
        do_reset();
        check("s6_queue_after_rst", 32'(exp_q.size()), 32'd0);
        push(8'h08, 4'd0);
        start_pulse();
        tick();
        halt_req = 1'b1;
        end_scn("s6_drained");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: simulation exceeded time limit, required completion");
        $fatal(1, "timeout");
    end

endmodule
